// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in system
// clock cycles, publishing one result per rising edge and flagging a stalled input.
module period_meter #(
    parameter int                     COUNT_WIDTH = 28,
    parameter logic [COUNT_WIDTH-1:0] TIMEOUT     = 28'd100000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   signal_in,
    input  logic                   measure_enable,
    output logic [COUNT_WIDTH-1:0] period,
    output logic [COUNT_WIDTH-1:0] high_time,
    output logic                   period_valid,
    output logic                   timeout,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic                   prev_q, prev_d;
    logic [COUNT_WIDTH-1:0] counter_q, counter_d;
    logic [COUNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [COUNT_WIDTH-1:0] period_q, period_d;
    logic [COUNT_WIDTH-1:0] high_time_q, high_time_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;
    logic                   busy_q, busy_d;
    logic                   rise, fall;

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            counter_q   <= '0;
            shadow_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            counter_q   <= counter_d;
            shadow_q    <= shadow_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    // period_valid is a one-cycle strobe with no back-pressure: period and
    // high_time change only in the cycle it is high and hold otherwise.
    always_comb begin
        sync1_d     = signal_in;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        state_d     = state_q;
        counter_d   = counter_q;
        shadow_d    = shadow_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;

        if (!measure_enable) begin
            state_d   = IDLE;
            counter_d = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARMED;
                    counter_d = '0;
                end
                ARMED: begin
                    // The first edge only starts timing; nothing is published.
                    if (rise) begin
                        state_d   = MEASURE;
                        counter_d = COUNT_WIDTH'(1);
                    end
                end
                MEASURE: begin
                    // A rise landing on counter == TIMEOUT still publishes.
                    if (rise) begin
                        period_d    = counter_q;
                        high_time_d = shadow_q;
                        valid_d     = 1'b1;
                        counter_d   = COUNT_WIDTH'(1);
                        timeout_d   = 1'b0;
                    end else if (counter_q == TIMEOUT) begin
                        timeout_d = 1'b1;
                        counter_d = '0;
                        state_d   = ARMED;
                    end else begin
                        counter_d = counter_q + COUNT_WIDTH'(1);
                        if (fall) begin
                            shadow_d = counter_q;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    counter_d = '0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: table-driven square waves plus hand sequences for
// timeout, enable drop and reset; results checked against an expected queue.
module tb_period_meter;

    localparam int             CW = 28;
    localparam logic [CW-1:0]  TO = 28'd20;
    localparam int             EW = 2 * CW + 32;

    logic          clock          = 1'b0;
    logic          reset_n        = 1'b0;
    logic          signal_in      = 1'b0;
    logic          measure_enable = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          period_valid;
    logic          timeout;
    logic          busy;

    period_meter #(
        .COUNT_WIDTH(CW),
        .TIMEOUT    (TO)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .signal_in     (signal_in),
        .measure_enable(measure_enable),
        .period        (period),
        .high_time     (high_time),
        .period_valid  (period_valid),
        .timeout       (timeout),
        .busy          (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cycle_cnt = 0;
    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [CW-1:0] mon_p   = '0;
    logic [CW-1:0] mon_h   = '0;
    logic          mon_v   = 1'b0;
    logic          mon_rst = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n && mon_rst) begin
            if (period_valid) begin
                check("no_back_to_back_strobe", 64'(mon_v), 64'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got period %0d high %0d, required no strobe (t=%0t)",
                             period, high_time, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("period", 64'(period), 64'(mon_e[EW-1 -: CW]));
                    check("high_time", 64'(high_time), 64'(mon_e[CW+31 -: CW]));
                    check("strobe_cycle", 64'(cycle_cnt), 64'(mon_e[31:0]));
                    check("timeout_clear_at_strobe", 64'(timeout), 64'd0);
                end
            end else begin
                check("period_hold", 64'(period), 64'(mon_p));
                check("high_time_hold", 64'(high_time), 64'(mon_h));
            end
        end
        mon_p   = period;
        mon_h   = high_time;
        mon_v   = period_valid;
        mon_rst = reset_n;
    end

    // ---------------- driver tasks ----------------
    bit            publish_en = 1'b0;
    bit            have_prev  = 1'b0;
    logic [CW-1:0] last_p     = '0;
    logic [CW-1:0] last_h     = '0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // n full periods, each starting with a rise; a rise publishes the
    // previous full period when the meter is already measuring.
    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            if (publish_en && have_prev)
                exp_q.push_back({last_p, last_h, 32'(cycle_cnt + 3)});
            signal_in = 1'b1;
            last_p    = CW'(p);
            last_h    = CW'(h);
            have_prev = publish_en;
            repeat (h) step();
            signal_in = 1'b0;
            repeat (p - h) step();
        end
    endtask

    task automatic drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            step();
            k++;
        end
        check("expected_strobes_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic enable_on();
        measure_enable = 1'b1;
        publish_en     = 1'b1;
        have_prev      = 1'b0;
        step();
        check("busy_after_enable", 64'(busy), 64'd1);
    endtask

    task automatic enable_off();
        measure_enable = 1'b0;
        publish_en     = 1'b0;
        have_prev      = 1'b0;
        step();
        check("busy_after_disable", 64'(busy), 64'd0);
    endtask

    // ---------------- test ----------------
    typedef struct {
        int p;
        int h;
        int n;
    } vec_t;

    vec_t vecs[5];
    int   c0;

    initial begin
        vecs[0] = '{p: 10, h: 5,  n: 4};
        vecs[1] = '{p: 7,  h: 1,  n: 3};
        vecs[2] = '{p: 7,  h: 6,  n: 3};
        vecs[3] = '{p: 2,  h: 1,  n: 4};
        vecs[4] = '{p: 20, h: 10, n: 3};

        step();
        step();
        check("reset_period", 64'(period), 64'd0);
        check("reset_high_time", 64'(high_time), 64'd0);
        check("reset_valid", 64'(period_valid), 64'd0);
        check("reset_timeout", 64'(timeout), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'd0);

        // continuous sweep; the last entry's period equals TIMEOUT
        enable_on();
        for (int i = 0; i < 5; i++) wave(vecs[i].p, vecs[i].h, vecs[i].n);
        drain(10);
        check("no_timeout_after_sweep", 64'(timeout), 64'd0);
        enable_off();

        // stalled input: timeout TIMEOUT cycles after the internal rise
        enable_on();
        c0        = cycle_cnt;
        signal_in = 1'b1;
        repeat (5) step();
        signal_in = 1'b0;
        while (cycle_cnt < c0 + int'(TO) + 2) step();
        check("timeout_not_yet", 64'(timeout), 64'd0);
        step();
        check("timeout_set", 64'(timeout), 64'd1);
        check("busy_during_timeout", 64'(busy), 64'd1);
        wave(8, 3, 1);
        check("timeout_held_after_rearm", 64'(timeout), 64'd1);
        wave(8, 3, 1);
        drain(10);
        check("timeout_cleared", 64'(timeout), 64'd0);
        enable_off();

        // enable dropped mid-period, then re-armed
        enable_on();
        wave(10, 5, 3);
        drain(10);
        enable_off();
        wave(6, 3, 3);
        check("hold_period_disabled", 64'(period), 64'd10);
        check("hold_high_disabled", 64'(high_time), 64'd5);
        check("busy_low_disabled", 64'(busy), 64'd0);
        enable_on();
        wave(6, 3, 3);
        drain(10);
        check("period_after_reenable", 64'(period), 64'd6);

        // reset pulse mid-measurement with enable held high
        signal_in = 1'b0;
        repeat (2) step();
        reset_n = 1'b0;
        step();
        check("rst_period", 64'(period), 64'd0);
        check("rst_high_time", 64'(high_time), 64'd0);
        check("rst_valid", 64'(period_valid), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        reset_n   = 1'b1;
        have_prev = 1'b0;
        step();
        check("busy_rearmed_after_reset", 64'(busy), 64'd1);
        wave(10, 5, 3);
        drain(10);

        check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period and high time of a slow asynchronous square wave, such as a divided stopwatch tick or an external reference, in cycles of the 50 MHz system clock. Measurement runs continuously while enabled: each new rising edge publishes one result with a single-cycle valid strobe. A timeout flags a missing or stalled input. The block sits beside the stopwatch timebase and verifies divider output frequency on hardware and in simulation.

## Interface
- COUNT_WIDTH, 28: width of the internal counter and of the result outputs.
- TIMEOUT, 28'd100000000: maximum cycles between rising edges before a timeout is flagged (2 s at 50 MHz). Requires 2 ≤ TIMEOUT ≤ 2^COUNT_WIDTH−1.
- clock  input  1  system clock, all logic on its rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- signal_in  input  1  asynchronous square wave under measurement.
- measure_enable  input  1  level; high = measure, low = idle.
- period  output  COUNT_WIDTH  clock cycles between the last two rising edges of signal_in.
- high_time  output  COUNT_WIDTH  clock cycles signal_in was high within that period.
- period_valid  output  1  one-cycle strobe; period and high_time are updated with it.
- timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.
- busy  output  1  high in ARMED or MEASURE.

## Operation
- Input path: 2-flop synchronizer (sync1, sync2), then history flop prev.
  - rise = sync2 & ~prev.
  - fall = ~sync2 & prev.
- counter: COUNT_WIDTH bits. Loads 1 on rise; otherwise increments by 1 in MEASURE.
- States:
  - IDLE: counter held at 0. measure_enable=1 → ARMED.
  - ARMED: waits for the first rise. Nothing is published. On rise → MEASURE, counter←1.
  - MEASURE, on fall: high_time_shadow←counter.
  - MEASURE, on rise: period←counter, high_time←high_time_shadow, period_valid=1, counter←1, timeout←0. State stays MEASURE.
  - MEASURE, counter==TIMEOUT with no rise: timeout←1, counter←0, → ARMED. The first edge after a timeout only re-arms and does not publish.
- measure_enable=0 in any state: → IDLE on the next edge, no strobe, timeout←0. period and high_time hold their last values.
- Rise and counter==TIMEOUT in the same cycle: the rise wins, the result is published, and timeout is not set.
- Counter never wraps. It is bounded by TIMEOUT ≤ 2^COUNT_WIDTH−1.
- Minimum resolvable period is 2 cycles, with the input high ≥1 and low ≥1 synchronized cycles. Shorter pulses may be lost in the synchronizer; this is accepted.

## Timing
- Reset values: period=0, high_time=0, period_valid=0, timeout=0, busy=0. All internal registers are 0, including sync1, sync2, prev, counter and the shadow. State is IDLE.
- reset_n low overrides everything, including measure_enable, mid-measurement.
- Latency: signal_in first sampled high at edge k → sync2 high after edge k+1 → rise during the cycle after edge k+1. period_valid is high for exactly the cycle after edge k+2. Total: 3 edges.
- period_valid is never high on two consecutive cycles.
- period and high_time change only in the same cycle that period_valid rises.
- busy is registered from state. It rises one edge after measure_enable is sampled high and falls one edge after it is sampled low.
- timeout rises on the edge where counter==TIMEOUT is sampled, i.e. TIMEOUT cycles after the last rise. It stays high until the next published result, measure_enable=0, or reset.

## Test plan
- Reset, then enable, then a square wave with period 10 and 5 high → first strobe is discarded (ARMED). Every later strobe gives period=10 and high_time=5, one strobe per 10 cycles, 3-edge latency from each input rise.
- Duty sweep with period 7 and high 1, then high 6 → period=7 with high_time=1, then period=7 with high_time=6. Period 2 with high 1 → period=2, high_time=1.
- TIMEOUT overridden to 20, input held low after one rise → timeout=1 on the edge 20 cycles after that rise, busy stays 1. The next rise does not strobe; the following rise strobes and clears timeout.
- Rise timed to coincide with counter==TIMEOUT (period exactly TIMEOUT) → period=TIMEOUT, period_valid=1, timeout stays 0.
- measure_enable dropped mid-period → no strobe, busy=0 one edge later, outputs hold old values. Re-enabling goes through ARMED again.
- reset_n pulsed low for one cycle mid-MEASURE with enable still high → all outputs 0. The block re-enters ARMED, and the first valid result is one full period after the first post-reset rise.
